// File: rtl/draw_scheduler_if.sv
// Command handshake between the draw scheduler (master) and the draw core (slave).
interface draw_scheduler_if #(
    parameter int CMD_W = 4,
    parameter int DW    = 32
) ();
    logic             oCore_en;
    logic [CMD_W-1:0] oCore_cmd;
    logic [DW-1:0]    oCore_data;
    logic             iCore_done;

    modport master (output oCore_en, oCore_cmd, oCore_data, input iCore_done);
    modport slave  (input oCore_en, oCore_cmd, oCore_data, output iCore_done);
endinterface

// File: rtl/draw_scheduler.sv
// Runs a power-on init list once, then redraws dirty screen items round-robin over one en/done
// handshake, with periodic forced refresh, a completion watchdog and a re-init request.
module draw_scheduler #(
    parameter int                         CMD_W          = 4,
    parameter int                         DW             = 32,
    parameter int                         NUM_INIT       = 3,
    parameter logic [NUM_INIT*CMD_W-1:0]  INIT_CMDS      = {4'd4, 4'd1, 4'd0},
    parameter int                         NUM_CH         = 4,
    parameter logic [NUM_CH*CMD_W-1:0]    CH_CMDS        = {4'd7, 4'd8, 4'd5, 4'd2},
    parameter int unsigned                REFRESH_CYCLES = 50_000_000,
    parameter int unsigned                TIMEOUT_CYCLES = 4_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 iReinit,
    input  logic [NUM_CH-1:0]    iUpd,
    input  logic [NUM_CH*DW-1:0] iData,
    draw_scheduler_if.master     core,
    output logic                 oBusy,
    output logic                 oInitDone,
    output logic                 oTimeout_err,
    output logic [3:0]           oCur_ch
);
    localparam int                IDX_W    = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_INIT - 1);
    localparam logic [NUM_CH-1:0] ALL_CH   = '1;

    typedef enum logic [2:0] {GAP, INIT_ISSUE, INIT_WAIT, IDLE, RUN_WAIT} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_core_en, w_core_en_nxt;
    logic [CMD_W-1:0]    r_cmd, w_cmd_nxt;
    logic [DW-1:0]       r_data, w_data_nxt;
    logic [3:0]          r_cur_ch, w_cur_ch_nxt;
    logic [3:0]          r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [NUM_CH-1:0]   r_dirty, w_set, w_clr;
    logic                r_init_done, w_init_done_nxt;
    logic                r_terr, w_terr_nxt;
    logic                r_pend, w_pend_nxt;
    logic                r_busy;
    logic [31:0]         r_wait_cnt, w_wait_cnt_nxt;
    logic [31:0]         r_ref_cnt;
    logic [2*NUM_CH-1:0] w_rot;
    logic [3:0]          w_pick;
    logic                w_pick_vld, w_refresh, w_timeout, w_done;

    assign w_done    = core.iCore_done & r_core_en;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wait_cnt >= TIMEOUT_CYCLES - 32'd1);
    assign w_refresh = (REFRESH_CYCLES != 0) && r_init_done && (r_ref_cnt == REFRESH_CYCLES - 32'd1);

    // Doubling the dirty vector lets a plain right shift by the pointer express the wrap-around scan.
    assign w_rot = {r_dirty, r_dirty} >> r_ptr;

    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_pick_vld && w_rot[i]) begin
                w_pick_vld = 1'b1;
                w_pick     = 4'((int'(r_ptr) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
        w_state_nxt     = r_state;
        w_core_en_nxt   = r_core_en;
        w_cmd_nxt       = r_cmd;
        w_data_nxt      = r_data;
        w_cur_ch_nxt    = r_cur_ch;
        w_ptr_nxt       = r_ptr;
        w_idx_nxt       = r_idx;
        w_init_done_nxt = r_init_done;
        w_terr_nxt      = r_terr;
        w_pend_nxt      = r_pend;
        w_wait_cnt_nxt  = '0;
        w_clr           = '0;
        w_set           = iUpd | (w_refresh ? ALL_CH : '0);

        unique case (r_state)
            GAP: begin
                if (r_pend) begin
                    w_pend_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = INIT_ISSUE;
                end else if (!r_init_done) begin
                    w_state_nxt = INIT_ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            INIT_ISSUE: begin
                if (en) begin
                    w_core_en_nxt = 1'b1;
                    w_cmd_nxt     = CMD_W'(INIT_CMDS >> (int'(r_idx) * CMD_W));
                    w_data_nxt    = '0;
                    w_state_nxt   = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt + 32'd1;
                if (w_done || w_timeout) begin
                    w_core_en_nxt = 1'b0;
                    w_state_nxt   = GAP;
                    if (!w_done) w_terr_nxt = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt = '0;
                        w_set     = ALL_CH;
                        // A pending re-init restarts the list at the gap; the list is not done yet.
                        if (!r_pend) w_init_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            IDLE: begin
                if (r_pend) begin
                    w_pend_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = INIT_ISSUE;
                end else if (en && w_pick_vld) begin
                    w_core_en_nxt = 1'b1;
                    w_cmd_nxt     = CMD_W'(CH_CMDS >> (int'(w_pick) * CMD_W));
                    w_data_nxt    = DW'(iData >> (int'(w_pick) * DW));
                    w_clr         = NUM_CH'(1) << w_pick;
                    w_cur_ch_nxt  = w_pick;
                    w_ptr_nxt     = (int'(w_pick) == NUM_CH - 1) ? 4'd0 : w_pick + 4'd1;
                    w_state_nxt   = RUN_WAIT;
                end
            end
            RUN_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt + 32'd1;
                if (w_done || w_timeout) begin
                    w_core_en_nxt = 1'b0;
                    w_state_nxt   = GAP;
                    if (!w_done) begin
                        w_terr_nxt = 1'b1;
                        w_set      = w_set | (NUM_CH'(1) << r_cur_ch);
                    end
                end
            end
            default: w_state_nxt = GAP;
        endcase

        if (iReinit) begin
            w_pend_nxt      = 1'b1;
            w_init_done_nxt = 1'b0;
            w_terr_nxt      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= GAP;
            r_core_en   <= 1'b0;
            r_cmd       <= '0;
            r_data      <= '0;
            r_cur_ch    <= '0;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_dirty     <= '0;
            r_init_done <= 1'b0;
            r_terr      <= 1'b0;
            r_pend      <= 1'b0;
            r_busy      <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_core_en   <= w_core_en_nxt;
            r_cmd       <= w_cmd_nxt;
            r_data      <= w_data_nxt;
            r_cur_ch    <= w_cur_ch_nxt;
            r_ptr       <= w_ptr_nxt;
            r_idx       <= w_idx_nxt;
            r_dirty     <= (r_dirty & ~w_clr) | w_set;
            r_init_done <= w_init_done_nxt;
            r_terr      <= w_terr_nxt;
            r_pend      <= w_pend_nxt;
            r_busy      <= w_core_en_nxt | (w_state_nxt == GAP);
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_ref_cnt <= '0;
        else if (!r_init_done || w_refresh) r_ref_cnt <= '0;
        else if (REFRESH_CYCLES != 0)       r_ref_cnt <= r_ref_cnt + 32'd1;
    end

    assign core.oCore_en   = r_core_en;
    assign core.oCore_cmd  = r_cmd;
    assign core.oCore_data = r_data;
    assign oBusy           = r_busy;
    assign oInitDone       = r_init_done;
    assign oTimeout_err    = r_terr;
    assign oCur_ch         = r_cur_ch;
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench: instance A (timeout 20, no refresh) and instance B (refresh 100, no timeout).
module tb_draw_scheduler;
    localparam int CMD_W = 4;
    localparam int DW = 32;
    localparam int NUM_CH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 a_rst_n, a_en, a_reinit, b_rst_n, b_en, b_reinit;
    logic [NUM_CH-1:0]    a_upd, b_upd;
    logic [NUM_CH*DW-1:0] a_idata, b_idata;
    logic                 a_busy, a_init_done, a_terr, b_busy, b_init_done, b_terr;
    logic [3:0]           a_cur_ch, b_cur_ch;

    draw_scheduler_if #(.CMD_W(CMD_W), .DW(DW)) ifa ();
    draw_scheduler_if #(.CMD_W(CMD_W), .DW(DW)) ifb ();

    draw_scheduler #(.TIMEOUT_CYCLES(20), .REFRESH_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .iReinit(a_reinit), .iUpd(a_upd), .iData(a_idata),
        .core(ifa), .oBusy(a_busy), .oInitDone(a_init_done), .oTimeout_err(a_terr), .oCur_ch(a_cur_ch));

    draw_scheduler #(.TIMEOUT_CYCLES(0), .REFRESH_CYCLES(100)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .iReinit(b_reinit), .iUpd(b_upd), .iData(b_idata),
        .core(ifb), .oBusy(b_busy), .oInitDone(b_init_done), .oTimeout_err(b_terr), .oCur_ch(b_cur_ch));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core models: done pulses after the 5th cycle of oCore_en (A can be told to stay silent).
    logic a_respond = 1'b1;
    int   a_dcnt = 0, b_dcnt = 0;
    always @(negedge clk) begin
        if (ifa.oCore_en && a_respond) begin
            a_dcnt <= a_dcnt + 1;
            ifa.iCore_done <= (a_dcnt == 4);
        end else begin
            a_dcnt <= 0;
            ifa.iCore_done <= 1'b0;
        end
        if (ifb.oCore_en) begin
            b_dcnt <= b_dcnt + 1;
            ifb.iCore_done <= (b_dcnt == 4);
        end else begin
            b_dcnt <= 0;
            ifb.iCore_done <= 1'b0;
        end
    end

    // Issue logs, one entry per rising oCore_en.
    logic [3:0]  a_cmd[$], a_ch[$], b_cmd[$];
    logic [31:0] a_dat[$];
    int          a_cyc[$], b_cyc[$];
    logic        a_prev = 1'b0, b_prev = 1'b0;
    always @(negedge clk) begin
        if (ifa.oCore_en && !a_prev) begin
            a_cmd.push_back(ifa.oCore_cmd);
            a_dat.push_back(ifa.oCore_data);
            a_ch.push_back(a_cur_ch);
            a_cyc.push_back(cyc);
        end
        if (ifb.oCore_en && !b_prev) begin
            b_cmd.push_back(ifb.oCore_cmd);
            b_cyc.push_back(cyc);
        end
        a_prev <= ifa.oCore_en;
        b_prev <= ifb.oCore_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_a(input int n, input int budget, input string tag);
        int k = 0;
        while (a_cmd.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, a_cmd.size(), n);
    endtask

    task automatic wait_b(input int n, input int budget, input string tag);
        int k = 0;
        while (b_cmd.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, b_cmd.size(), n);
    endtask

    logic [3:0] init_exp [3] = '{4'd0, 4'd1, 4'd4};
    logic [3:0] ch_exp   [4] = '{4'd2, 4'd5, 4'd8, 4'd7};
    logic [3:0] b_exp    [9] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd4, 4'd2, 4'd5, 4'd8, 4'd7};
    logic [3:0] seq_exp  [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c0, k;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_en = 1'b1; b_en = 1'b1;
        a_reinit = 1'b0; b_reinit = 1'b0;
        a_upd = '0; b_upd = '0;
        b_idata = '0;
        for (int i = 0; i < NUM_CH; i++) a_idata[i*DW +: DW] = 32'hA0 + i;
        settle(3);
        check("rst_core_en", ifa.oCore_en, 0);
        check("rst_busy", a_busy, 0);
        check("rst_init_done", a_init_done, 0);
        check("rst_timeout_err", a_terr, 0);
        check("rst_cur_ch", a_cur_ch, 0);
        check("rst_b_core_en", ifb.oCore_en, 0);

        // Init list, then one draw of every item.
        tick();
        a_rst_n = 1'b1;
        wait_a(7, 300, "init_reach");
        for (int i = 0; i < 3; i++) check($sformatf("init_cmd%0d", i), a_cmd[i], init_exp[i]);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init_item_cmd%0d", i), a_cmd[3+i], ch_exp[i]);
            check($sformatf("init_item_ch%0d", i), a_ch[3+i], i);
            check($sformatf("init_item_dat%0d", i), a_dat[3+i], 32'hA0 + i);
        end
        check("init_done", a_init_done, 1);
        settle(20);

        // All items dirty while en=0; nothing issues until en returns.
        base = a_cmd.size();
        tick(); a_en = 1'b0; a_upd = 4'b1111;
        tick(); a_upd = '0;
        settle(10);
        check("en_low_no_issue", a_cmd.size(), base);
        tick(); a_en = 1'b1;
        wait_a(base + 2, 100, "en_seq_reach2");
        tick(); a_upd = 4'b0001;
        tick(); a_upd = '0;
        wait_a(base + 5, 200, "en_seq_reach5");
        for (int i = 0; i < 5; i++) check($sformatf("en_seq_ch%0d", i), a_ch[base+i], seq_exp[i]);
        settle(20);

        // Issue latency and data snapshot.
        base = a_cmd.size();
        tick(); a_idata[2*DW +: DW] = 32'h1234; a_upd = 4'b0100; c0 = cyc;
        tick(); a_upd = '0;
        wait_a(base + 1, 50, "lat_reach");
        check("lat_cycles", a_cyc[base] - c0, 2);
        check("lat_cmd", a_cmd[base], 8);
        check("lat_data", a_dat[base], 32'h1234);
        check("lat_cur_ch", a_cur_ch, 2);
        a_idata[2*DW +: DW] = 32'hDEAD;
        settle(2);
        check("snap_en", ifa.oCore_en, 1);
        check("snap_data", ifa.oCore_data, 32'h1234);
        settle(20);

        // Update in the very cycle item 1 is issued: set beats clear, one extra draw.
        base = a_cmd.size();
        tick(); a_upd = 4'b0010;
        tick();
        tick(); a_upd = '0;
        wait_a(base + 2, 100, "setclr_reach");
        settle(20);
        check("setclr_count", a_cmd.size(), base + 2);
        check("setclr_ch", a_ch[base+1], 1);

        // Update while item 1 is in flight: exactly one more draw.
        base = a_cmd.size();
        tick(); a_upd = 4'b0010;
        tick(); a_upd = '0;
        wait_a(base + 1, 50, "inflight_reach1");
        tick(); a_upd = 4'b0010;
        tick(); a_upd = '0;
        wait_a(base + 2, 100, "inflight_reach2");
        settle(20);
        check("inflight_count", a_cmd.size(), base + 2);
        check("inflight_ch", a_ch[base+1], 1);

        // Silent core: watchdog drops en after 20 wait cycles, sets the error, retries the item.
        base = a_cmd.size();
        a_respond = 1'b0;
        tick(); a_upd = 4'b1000;
        tick(); a_upd = '0;
        wait_a(base + 1, 50, "to_reach");
        k = 1;
        while (k < 100) begin
            @(negedge clk);
            #1;
            if (!ifa.oCore_en) break;
            k++;
        end
        check("to_en_cycles", k, 20);
        check("to_err", a_terr, 1);
        a_respond = 1'b1;
        wait_a(base + 2, 50, "to_retry_reach");
        check("to_retry_ch", a_ch[base+1], 3);
        check("to_retry_cmd", a_cmd[base+1], 7);
        settle(15);
        check("to_err_sticky", a_terr, 1);

        // Re-init clears error and done at once, reruns the list, redraws everything.
        base = a_cmd.size();
        tick(); a_reinit = 1'b1;
        tick(); a_reinit = 1'b0;
        check("reinit_err_clr", a_terr, 0);
        check("reinit_done_clr", a_init_done, 0);
        wait_a(base + 7, 300, "reinit_reach");
        for (int i = 0; i < 3; i++) check($sformatf("reinit_cmd%0d", i), a_cmd[base+i], init_exp[i]);
        for (int i = 0; i < 4; i++) check($sformatf("reinit_item%0d", i), a_cmd[base+3+i], ch_exp[i]);
        check("reinit_done", a_init_done, 1);

        // Instance B: re-init during init restarts at entry 0, then periodic refresh.
        tick(); b_rst_n = 1'b1;
        wait_b(2, 100, "b_init_reach2");
        tick(); b_reinit = 1'b1;
        tick(); b_reinit = 1'b0;
        wait_b(9, 300, "b_init_reach9");
        for (int i = 0; i < 9; i++) check($sformatf("b_seq%0d", i), b_cmd[i], b_exp[i]);
        check("b_init_done", b_init_done, 1);
        wait_b(21, 500, "b_refresh_reach");
        for (int i = 0; i < 12; i++) check($sformatf("b_ref_cmd%0d", i), b_cmd[9+i], ch_exp[i%4]);
        check("b_ref_period1", b_cyc[13] - b_cyc[9], 100);
        check("b_ref_period2", b_cyc[17] - b_cyc[13], 100);
        check("b_timeout_err", b_terr, 0);

        // Asynchronous reset mid-command, list restarts from entry 0.
        wait_b(22, 200, "b_rst_reach");
        #2;
        b_rst_n = 1'b0;
        #1;
        check("b_async_rst_en", ifb.oCore_en, 0);
        check("b_async_rst_done", b_init_done, 0);
        tick(); b_rst_n = 1'b1;
        wait_b(23, 50, "b_restart_reach");
        check("b_restart_cmd", b_cmd[22], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
